// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control FSM.
// Define JUMP_EN to add the JUMP state and opcode 2 support.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    R_EXEC   = 4'd6,
    R_WB     = 4'd7,
    BRANCH   = 4'd8,
    HALT     = 4'd9
`ifdef JUMP_EN
    , JUMP   = 4'd10
`endif
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_J     = 6'd2;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUSRCB_REG   = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_BROFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam int unsigned WAIT_CNT_W = 8;

  // States that stall on mem_ready and therefore run the wait timer.
  function automatic logic is_wait_state(state_e s);
    return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles and flags the cycle whose increment reaches TIMEOUT_CYCLES.
module mem_wait_timer
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic expire
);

  logic [WAIT_CNT_W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (inc) begin
      count_q <= count_q + 8'd1;
    end
  end

  // Fires on the wait cycle that would take the count to TIMEOUT_CYCLES.
  assign expire = inc && (count_q == 8'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS datapath control FSM with memory wait timeout and sticky error.
// Define JUMP_EN to decode opcode 2 into the JUMP state.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       err
);

  state_e state_q;
  logic   err_q;
  logic   in_wait;
  logic   expire;

  assign in_wait = is_wait_state(state_q);

  mem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (mem_ready || !in_wait),
    .inc   (in_wait && !mem_ready),
    .expire(expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (mem_ready) begin
            state_q <= DECODE;
          end else if (expire) begin
            state_q <= HALT;
            err_q   <= 1'b1;
          end
        end
        DECODE: begin
          case (opcode)
            OP_RTYPE:     state_q <= R_EXEC;
            OP_LW, OP_SW: state_q <= MEM_ADDR;
            OP_BEQ:       state_q <= BRANCH;
`ifdef JUMP_EN
            OP_J:         state_q <= JUMP;
`endif
            default: begin
              state_q <= FETCH;
              err_q   <= 1'b1;
            end
          endcase
        end
        MEM_ADDR: state_q <= (opcode == OP_LW) ? MEM_RD : MEM_WR;
        MEM_RD: begin
          if (mem_ready) begin
            state_q <= MEM_WB;
          end else if (expire) begin
            state_q <= HALT;
            err_q   <= 1'b1;
          end
        end
        MEM_WB: state_q <= FETCH;
        MEM_WR: begin
          if (mem_ready) begin
            state_q <= FETCH;
          end else if (expire) begin
            state_q <= HALT;
            err_q   <= 1'b1;
          end
        end
        R_EXEC: state_q <= R_WB;
        R_WB:   state_q <= FETCH;
        BRANCH: state_q <= FETCH;
`ifdef JUMP_EN
        JUMP:   state_q <= FETCH;
`endif
        HALT:   state_q <= HALT;
        default: state_q <= FETCH;
      endcase
    end
  end

  // Outputs decode from the state register; reset masks every strobe while held.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = ALUSRCB_REG;
    ALUOp       = ALUOP_ADD;
    PCSource    = PCSRC_ALU;
    instr_done  = 1'b0;
    if (!rst) begin
      unique case (state_q)
        FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = ALUSRCB_FOUR;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        DECODE:   ALUSrcB = ALUSRCB_BROFF;
        MEM_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = ALUSRCB_IMM;
        end
        MEM_RD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        MEM_WB: begin
          RegWrite   = 1'b1;
          MemtoReg   = 1'b1;
          instr_done = 1'b1;
        end
        MEM_WR: begin
          MemWrite   = 1'b1;
          IorD       = 1'b1;
          instr_done = mem_ready;
        end
        R_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = ALUOP_FUNCT;
        end
        R_WB: begin
          RegWrite   = 1'b1;
          RegDst     = 1'b1;
          instr_done = 1'b1;
        end
        BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = ALUOP_SUB;
          PCWriteCond = 1'b1;
          PCSource    = PCSRC_ALUOUT;
          instr_done  = 1'b1;
        end
`ifdef JUMP_EN
        JUMP: begin
          PCWrite    = 1'b1;
          PCSource   = PCSRC_JUMP;
          instr_done = 1'b1;
        end
`endif
        HALT: ;
        default: ;
      endcase
    end
  end

  assign state = state_q;
  assign err   = err_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control (TIMEOUT_CYCLES=4).
module tb_multicycle_control;
  import mips_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;
  logic       instr_done, err;

  int checks = 0;
  int failures = 0;

  multicycle_control #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .PCWriteCond(PCWriteCond),
    .IorD       (IorD),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .MemtoReg   (MemtoReg),
    .RegDst     (RegDst),
    .RegWrite   (RegWrite),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUOp      (ALUOp),
    .PCSource   (PCSource),
    .state      (state),
    .instr_done (instr_done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at posedge+1 of the first post-reset cycle (state FETCH).
  task automatic apply_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    opcode = OP_RTYPE;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_ready = 1'b1;
    opcode = OP_RTYPE;
    tick();
    #3;
    checks++;
    if (state !== 4'd0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: state=%0d err=%0d, required state=0 err=0", state, err);
    end
    checks++;
    if ({MemRead, IRWrite, PCWrite, instr_done, ALUSrcB} !== 6'b0) begin
      failures++;
      $display("FAIL reset_strobes: MemRead=%0b IRWrite=%0b PCWrite=%0b done=%0b ALUSrcB=%0b, required 0",
               MemRead, IRWrite, PCWrite, instr_done, ALUSrcB);
    end
    tick();
    rst = 1'b0;
    #3;
    checks++;
    if (state !== 4'(FETCH) || {MemRead, IRWrite, PCWrite} !== 3'b111) begin
      failures++;
      $display("FAIL reset_release: state=%0d MemRead/IRWrite/PCWrite=%03b, required 0 and 111",
               state, {MemRead, IRWrite, PCWrite});
    end
    tick();
    #3;
    checks++;
    if (state !== 4'(DECODE) || ALUSrcB !== 2'b11) begin
      failures++;
      $display("FAIL reset_decode: state=%0d ALUSrcB=%0b, required %0d and 11",
               state, ALUSrcB, DECODE);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (state !== 4'(FETCH) || MemRead !== 1'b0 || ALUSrcB !== 2'b00) begin
      failures++;
      $display("FAIL reset_async: state=%0d MemRead=%0b ALUSrcB=%0b, required 0 0 00",
               state, MemRead, ALUSrcB);
    end
    tick();
    rst = 1'b0;
    #3;
    checks++;
    if (state !== 4'(FETCH)) begin
      failures++;
      $display("FAIL reset_abandon: state=%0d, required %0d", state, FETCH);
    end
  endtask

  task automatic test_fetch_wait();
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      mem_ready = (c == 2);
      #3;
      checks++;
      if (state !== 4'(FETCH) || MemRead !== 1'b1 || IorD !== 1'b0 ||
          IRWrite !== mem_ready || PCWrite !== mem_ready) begin
        failures++;
        $display("FAIL fetch_wait cycle %0d: state=%0d MemRead=%0b IorD=%0b IRWrite=%0b PCWrite=%0b, required FETCH 1 0 %0b %0b",
                 c + 1, state, MemRead, IorD, IRWrite, PCWrite, mem_ready, mem_ready);
      end
      tick();
    end
    #3;
    checks++;
    if (state !== 4'(DECODE)) begin
      failures++;
      $display("FAIL fetch_wait_exit: state=%0d, required %0d", state, DECODE);
    end
  endtask

  task automatic test_rtype();
    state_e exp_st [5];
    bit     exp_wb [5];
    exp_st = '{FETCH, DECODE, R_EXEC, R_WB, FETCH};
    exp_wb = '{0, 0, 0, 1, 0};
    apply_reset();
    mem_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) opcode = OP_LW;  // must be ignored once past DECODE
      #3;
      checks++;
      if (state !== 4'(exp_st[c])) begin
        failures++;
        $display("FAIL rtype_state cycle %0d: state=%0d, required %0d", c + 1, state, exp_st[c]);
      end
      checks++;
      if (instr_done !== exp_wb[c] || RegWrite !== exp_wb[c] || RegDst !== exp_wb[c]) begin
        failures++;
        $display("FAIL rtype_wb cycle %0d: done=%0b RegWrite=%0b RegDst=%0b, required %0b",
                 c + 1, instr_done, RegWrite, RegDst, exp_wb[c]);
      end
      if (c == 2) begin
        checks++;
        if (ALUOp !== 2'b10 || ALUSrcA !== 1'b1) begin
          failures++;
          $display("FAIL rtype_exec: ALUOp=%0b ALUSrcA=%0b, required 10 1", ALUOp, ALUSrcA);
        end
      end
      tick();
    end
  endtask

  task automatic test_lw();
    state_e exp_st [9];
    bit     mr     [9];
    bit     exp_wb [9];
    exp_st = '{FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_RD, MEM_RD, MEM_RD, MEM_WB, FETCH};
    mr     = '{1, 1, 1, 0, 0, 0, 1, 1, 1};
    exp_wb = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
    apply_reset();
    opcode = OP_LW;
    for (int c = 0; c < 9; c++) begin
      mem_ready = mr[c];
      #3;
      checks++;
      if (state !== 4'(exp_st[c])) begin
        failures++;
        $display("FAIL lw_state cycle %0d: state=%0d, required %0d", c + 1, state, exp_st[c]);
      end
      checks++;
      if (MemtoReg !== exp_wb[c] || instr_done !== exp_wb[c]) begin
        failures++;
        $display("FAIL lw_wb cycle %0d: MemtoReg=%0b done=%0b, required %0b",
                 c + 1, MemtoReg, instr_done, exp_wb[c]);
      end
      tick();
    end
  endtask

  task automatic test_sw();
    state_e exp_st [5];
    bit     exp_wr [5];
    bit     exp_dn [5];
    exp_st = '{FETCH, DECODE, MEM_ADDR, MEM_WR, FETCH};
    exp_wr = '{0, 0, 0, 1, 0};
    exp_dn = '{0, 0, 0, 1, 0};
    apply_reset();
    opcode = OP_SW;
    mem_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #3;
      checks++;
      if (state !== 4'(exp_st[c]) || MemWrite !== exp_wr[c] || instr_done !== exp_dn[c]) begin
        failures++;
        $display("FAIL sw cycle %0d: state=%0d MemWrite=%0b done=%0b, required %0d %0b %0b",
                 c + 1, state, MemWrite, instr_done, exp_st[c], exp_wr[c], exp_dn[c]);
      end
      tick();
    end
  endtask

  task automatic test_beq();
    state_e     exp_st [4];
    logic [1:0] exp_op [4];
    bit         exp_br [4];
    exp_st = '{FETCH, DECODE, BRANCH, FETCH};
    exp_op = '{2'b00, 2'b00, 2'b01, 2'b00};
    exp_br = '{0, 0, 1, 0};
    apply_reset();
    opcode = OP_BEQ;
    mem_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #3;
      checks++;
      if (state !== 4'(exp_st[c]) || ALUOp !== exp_op[c]) begin
        failures++;
        $display("FAIL beq_state cycle %0d: state=%0d ALUOp=%0b, required %0d %0b",
                 c + 1, state, ALUOp, exp_st[c], exp_op[c]);
      end
      checks++;
      if (PCWriteCond !== exp_br[c] || PCSource !== {1'b0, exp_br[c]} || instr_done !== exp_br[c]) begin
        failures++;
        $display("FAIL beq_strobes cycle %0d: PCWriteCond=%0b PCSource=%0b done=%0b, required %0b",
                 c + 1, PCWriteCond, PCSource, instr_done, exp_br[c]);
      end
      tick();
    end
  endtask

  task automatic test_illegal();
    state_e exp_st  [4];
    bit     exp_err [4];
    exp_st  = '{FETCH, DECODE, FETCH, DECODE};
    exp_err = '{0, 0, 1, 1};
    apply_reset();
    opcode = 6'd63;
    mem_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #3;
      checks++;
      if (state !== 4'(exp_st[c]) || err !== exp_err[c]) begin
        failures++;
        $display("FAIL illegal cycle %0d: state=%0d err=%0b, required %0d %0b",
                 c + 1, state, err, exp_st[c], exp_err[c]);
      end
      checks++;
      if ({instr_done, RegWrite, MemWrite} !== 3'b000) begin
        failures++;
        $display("FAIL illegal_strobes cycle %0d: done/RegWrite/MemWrite=%03b, required 000",
                 c + 1, {instr_done, RegWrite, MemWrite});
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    state_e exp_st [10];
    bit     exp_wr [10];
    exp_st = '{FETCH, DECODE, MEM_ADDR, MEM_WR, MEM_WR, MEM_WR, MEM_WR, HALT, HALT, HALT};
    exp_wr = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 0};
    apply_reset();
    opcode = OP_SW;
    for (int c = 0; c < 10; c++) begin
      mem_ready = (c < 2) || (c >= 8);
      #3;
      checks++;
      if (state !== 4'(exp_st[c]) || MemWrite !== exp_wr[c] || err !== (c >= 7)) begin
        failures++;
        $display("FAIL timeout cycle %0d: state=%0d MemWrite=%0b err=%0b, required %0d %0b %0b",
                 c + 1, state, MemWrite, err, exp_st[c], exp_wr[c], (c >= 7));
      end
      tick();
    end
    rst = 1'b1;
    #1;
    checks++;
    if (state !== 4'(FETCH) || err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_reset: state=%0d err=%0b, required 0 0", state, err);
    end
    tick();
    rst = 1'b0;
    #3;
    checks++;
    if (state !== 4'(FETCH) || err !== 1'b0 || MemRead !== 1'b1) begin
      failures++;
      $display("FAIL timeout_release: state=%0d err=%0b MemRead=%0b, required 0 0 1",
               state, err, MemRead);
    end
  endtask

  task automatic test_jump();
    apply_reset();
    opcode = OP_J;
    mem_ready = 1'b1;
    tick();
    tick();
    #3;
`ifdef JUMP_EN
    checks++;
    if (state !== 4'(JUMP) || PCWrite !== 1'b1 || PCSource !== 2'b10 || instr_done !== 1'b1) begin
      failures++;
      $display("FAIL jump: state=%0d PCWrite=%0b PCSource=%0b done=%0b, required %0d 1 10 1",
               state, PCWrite, PCSource, instr_done, JUMP);
    end
    tick();
    #3;
    checks++;
    if (state !== 4'(FETCH) || err !== 1'b0) begin
      failures++;
      $display("FAIL jump_return: state=%0d err=%0b, required 0 0", state, err);
    end
`else
    checks++;
    if (state !== 4'(FETCH) || err !== 1'b1 || instr_done !== 1'b0) begin
      failures++;
      $display("FAIL jump_illegal: state=%0d err=%0b done=%0b, required 0 1 0",
               state, err, instr_done);
    end
`endif
  endtask

  initial begin
    rst = 1'b1;
    opcode = OP_RTYPE;
    mem_ready = 1'b0;
    test_reset();
    test_fetch_wait();
    test_rtype();
    test_lw();
    test_sw();
    test_beq();
    test_illegal();
    test_timeout();
    test_jump();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16: the maximum number of cycles to wait for mem_ready (legal range 2..255).
REQ-002 clk  in  1  system clock, rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 opcode  in  6  IR[31:26].
REQ-005 mem_ready  in  1  memory completes the pending access this cycle.
REQ-006 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA  out  1 each  multi-cycle datapath strobes and selects.
REQ-007 ALUSrcB, ALUOp, PCSource  out  2 each; ALUOp encoding: 00 add, 01 sub, 10 funct-decoded.
REQ-008 state  out  4  current state; instr_done  out  1  one-cycle retire pulse; err  out  1  sticky error flag.

Function
REQ-009 The FSM SHALL have states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, BRANCH and HALT, plus JUMP when JUMP_EN is defined.
REQ-010 Every output SHALL be 0 unless it is listed for the current state; outputs decode from the state register, and mem_ready-qualified strobes are combinational on mem_ready.
REQ-011 FETCH SHALL drive MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, and hold while mem_ready=0; on mem_ready=1 it SHALL drive IRWrite=1 and PCWrite=1 in the same cycle, then go to DECODE.
REQ-012 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, ALUOp=00, then branch on opcode: 0 to R_EXEC, 35/43 to MEM_ADDR, 4 to BRANCH; any other opcode SHALL go to FETCH with err set and no instr_done.
REQ-013 MEM_ADDR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00, then go to MEM_RD if opcode=35, else MEM_WR.
REQ-014 MEM_RD SHALL drive MemRead=1, IorD=1, and hold until mem_ready, then go to MEM_WB.
REQ-015 MEM_WB SHALL drive RegWrite=1, RegDst=0, MemtoReg=1, instr_done=1, then go to FETCH.
REQ-016 MEM_WR SHALL drive MemWrite=1, IorD=1, and hold until mem_ready; on mem_ready it SHALL drive instr_done=1 and go to FETCH.
REQ-017 R_EXEC SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=10, then go to R_WB.
REQ-018 R_WB SHALL drive RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1, then go to FETCH.
REQ-019 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1, then go to FETCH.
REQ-020 With zero-wait memory, the FETCH-to-FETCH latency SHALL be: beq 3 cycles, R-type 4, sw 4, lw 5; each wait cycle adds 1.
REQ-021 The wait counter SHALL be 8 bits wide and cleared on entry to FETCH/MEM_RD/MEM_WR and on mem_ready; it SHALL increment on each wait cycle, and when count==TIMEOUT_CYCLES the FSM SHALL go to HALT with err=1.
REQ-022 HALT SHALL drive all outputs 0 (except err and state) and SHALL be exited only by rst.
REQ-023 opcode SHALL be used only in DECODE and MEM_ADDR; changes to it in other states SHALL have no effect.

Reset
REQ-024 rst=1 SHALL immediately force state=FETCH (encoding 0), wait counter=0 and err=0, and SHALL force all strobes and instr_done to 0 while asserted.
REQ-025 Reset mid-instruction SHALL abandon that instruction, and the first cycle after release SHALL be FETCH.

Configuration
REQ-026 With JUMP_EN defined, opcode 2 SHALL go from DECODE to JUMP; JUMP SHALL drive PCWrite=1, PCSource=10, instr_done=1, then go to FETCH (3 cycles total).
REQ-027 With JUMP_EN undefined, opcode 2 SHALL be illegal per REQ-012, and no JUMP state SHALL exist.

Structure
REQ-028 Package mips_ctrl_pkg SHALL hold the state enum (4-bit, FETCH=0), the opcode constants OP_RTYPE=0, OP_LW=35, OP_SW=43, OP_BEQ=4, OP_J=2, and the ALUOp/ALUSrcB/PCSource encodings.
REQ-029 The block SHALL contain one sub-module, mem_wait_timer (wait counter plus timeout compare), with the FSM in the top level.

Verification
REQ-030 The bench SHALL cover: rst release, mem_ready=1, opcode=0 -> FETCH, DECODE, R_EXEC, R_WB, FETCH; instr_done in cycle 4; RegWrite=1 and RegDst=1 only in R_WB.
REQ-031 The bench SHALL cover: opcode=35, mem_ready=0 for 3 cycles in MEM_RD -> MEM_RD lasts 4 cycles, 8 cycles total, MemtoReg=1 in MEM_WB.
REQ-032 The bench SHALL cover: opcode=4 -> retires in 3 cycles; PCWriteCond=1, ALUOp=01, PCSource=01 only in BRANCH.
REQ-033 The bench SHALL cover: opcode=63 -> DECODE then FETCH, err=1, no instr_done, RegWrite and MemWrite never asserted.
REQ-034 The bench SHALL cover: TIMEOUT_CYCLES=4, mem_ready=0 in MEM_WR -> HALT after 4 wait cycles, err=1, MemWrite=0; then rst -> FETCH with err=0.
REQ-035 The bench SHALL cover: opcode=2 with JUMP_EN -> PCWrite=1, PCSource=10 in cycle 3; opcode=2 without JUMP_EN -> err=1.
